regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Sequences the 32x32 register file's single write port. After reset it zero-fills
//  every architectural register (the array itself has no reset). Then it shares the
//  port between two write-back requesters: A = ALU result, B = load/memory result.
//  Sits between the execute/memory stages and the register file write inputs.
// PARAMETERS
//  NUM_REGS       32  number of registers; register 0 is hard-wired zero
//  ADDR_W          5  register index width, clog2(NUM_REGS)
//  DATA_W         32  write data width
//  INIT_ON_RESET   1  1: run the zero-fill sequence after reset; 0: go straight to RUN
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  a_valid     in   1       requester A has a write pending
//  a_ready     out  1       A's write is accepted this cycle
//  a_addr      in   ADDR_W  A's destination register
//  a_data      in   DATA_W  A's write data
//  b_valid     in   1       requester B has a write pending
//  b_ready     out  1       B's write is accepted this cycle
//  b_addr      in   ADDR_W  B's destination register
//  b_data      in   DATA_W  B's write data
//  rf_we       out  1       drives the register file write_enable
//  rf_waddr    out  ADDR_W  drives the register file write_register
//  rf_wdata    out  DATA_W  drives the register file write_data
//  init_done   out  1       1 once the zero-fill is complete; stays 1 until reset
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0,
//    last_grant=B so that A wins the first tie. State goes to INIT, or to RUN with
//    init_done=1 if INIT_ON_RESET=0.
//  - Asserting rst_n mid-sequence or mid-transfer aborts it; any pending write is dropped.
//  - rf_* outputs are registered. Latency is 1 cycle: an accepted request appears on
//    rf_* in the next cycle, so the register file captures it at the following edge.
//  - FSM INIT: init counter cnt starts at 1.
//    - Each cycle: rf_we=1, rf_waddr=cnt, rf_wdata=0, cnt++.
//    - After rf_waddr=NUM_REGS-1 has been driven, the next cycle enters RUN with
//      init_done=1. This means 31 write cycles when NUM_REGS=32.
//    - a_ready=b_ready=0 throughout INIT.
//  - FSM RUN:
//    - Handshake: a transfer occurs when x_valid && x_ready. x_ready is combinational
//      from the x_valid inputs and last_grant. At most one of a_ready/b_ready is high.
//    - Grant rules:
//      - Only A valid -> grant A.
//      - Only B valid -> grant B.
//      - Both valid -> grant the requester NOT equal to last_grant (round-robin).
//      - Neither valid -> rf_we=0 next cycle, last_grant unchanged.
//    - On a grant, last_grant updates to the granted requester.
//    - The ungranted requester must hold valid/addr/data stable until it is accepted.
//    - Writes to address 0: the handshake completes normally but rf_we=0 next cycle.
//      Register 0 must never be written.
//    - rf_waddr/rf_wdata follow the granted request even when rf_we=0.
//  - Requesters see no write-to-read hazard logic; forwarding lives elsewhere.
// TESTING
//  1. Reset, then idle.
//     -> rf_we=1 for 31 consecutive cycles, rf_waddr=1..31, rf_wdata=0.
//     -> init_done rises on the cycle after addr 31; no ready asserted during INIT.
//  2. After init, A: valid=1, addr=5, data=0xDEADBEEF for one cycle.
//     -> a_ready=1 that cycle.
//     -> Next cycle: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//  3. A (addr 3, data 0x11) and B (addr 4, data 0x22) both held valid.
//     -> A is granted first, B on the following cycle.
//     -> rf_* shows addr 3 then addr 4 on back-to-back cycles; each ready pulses once.
//  4. B: addr=0, data=0xFFFFFFFF.
//     -> b_ready=1; next cycle rf_we=0; a read of register 0 still returns 0.
//  5. Pulse rst_n low while INIT is at cnt=10.
//     -> Outputs clear immediately (asynchronously).
//     -> On release, INIT restarts from addr 1.
//  6. A and B both held valid continuously for 8 cycles.
//     -> Grants strictly alternate A,B,A,B,...; neither requester starves.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer for the register file: zero-fills registers 1..NUM_REGS-1 after
// reset, then round-robins the single write port between ALU (A) and load (B) write-back.
module regfile_wb_arbiter #(
  parameter int NUM_REGS      = 32,
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // cnt is one bit wider than an address so it can reach NUM_REGS, which marks the
  // single idle cycle between the last fill write and RUN.
  localparam logic [ADDR_W:0] INIT_END = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0] CNT_START = (ADDR_W + 1)'(1);

  state_t          state;
  state_t          state_next;
  logic [ADDR_W:0] cnt;
  logic            init_last;
  logic            last_grant_b;
  logic            grant_a;
  logic            grant_b;

  assign init_last = (cnt == INIT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_ON_RESET != 0) state <= ST_INIT;
      else                    state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_last) state_next = ST_RUN;
  end

  // Handshake: a write transfers on a cycle where x_valid && x_ready. x_ready is
  // combinational from both valids and last_grant, is only ever high in RUN, and at
  // most one ready is high. An unaccepted requester holds valid/addr/data stable.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_RUN) begin
      if (a_valid && b_valid) begin
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign init_done = (state == ST_RUN);

  // Registered write port; register 0 writes complete the handshake but never strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      cnt          <= CNT_START;
      last_grant_b <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (!init_last) begin
            rf_we    <= 1'b1;
            rf_waddr <= cnt[ADDR_W-1:0];
            rf_wdata <= '0;
            cnt      <= cnt + CNT_START;
          end else begin
            rf_we <= 1'b0;
          end
        end
        ST_RUN: begin
          if (grant_a) begin
            rf_we        <= (a_addr != '0);
            rf_waddr     <= a_addr;
            rf_wdata     <= a_data;
            last_grant_b <= 1'b0;
          end else if (grant_b) begin
            rf_we        <= (b_addr != '0);
            rf_waddr     <= b_addr;
            rf_wdata     <= b_data;
            last_grant_b <= 1'b1;
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));
  no_reg0_write:  assert property (@(posedge clk) disable iff (!rst_n) !(rf_we && rf_waddr == '0));

endmodule
